// File: rtl/muldiv_unit.sv
// Iterative 64-bit multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, fixed latency, writes its result straight into the register file port.
module muldiv_unit #(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [4:0]   rd,
   output logic         busy,
   output logic         done,
   output logic         we3,
   output logic [4:0]   wa3,
   output logic [N-1:0] wd3
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t         state_q, state_d;
   logic [1:0]     op_q;
   logic [N-1:0]   a_q, b_q, mplr_q, quo_q;
   logic [4:0]     rd_q, wa3_q;
   logic [CW-1:0]  cnt_q;
   logic [2*N-1:0] prod_q;
   logic [N:0]     rem_q;
   logic [N-1:0]   wd3_q;

   logic           calc_end;
   logic [N:0]     psum;
   logic [2*N-1:0] prod_next;
   logic [N+1:0]   rem_shift, trial;
   logic           fits;
   logic [N:0]     rem_next;
   logic [N-1:0]   quo_next, result;

   // cnt_q runs 0..N-1 doing one iteration per cycle; at N the result is loaded.
   assign calc_end = (cnt_q == CW'(N));

   always_comb begin
      psum      = {1'b0, prod_q[2*N-1:N]} + (mplr_q[0] ? {1'b0, a_q} : '0);
      prod_next = {psum, prod_q[N-1:1]};
      // Next dividend bit comes from the top of the quotient shift register.
      rem_shift = {rem_q, quo_q[N-1]};
      trial     = rem_shift - {2'b00, b_q};
      fits      = ~trial[N+1];
      rem_next  = fits ? trial[N:0] : rem_shift[N:0];
      quo_next  = {quo_q[N-2:0], fits};
      case (op_q)
         2'b00:   result = prod_q[N-1:0];
         2'b01:   result = prod_q[2*N-1:N];
         2'b10:   result = (b_q == '0) ? '0 : quo_q;
         default: result = rem_q[N-1:0];
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CALC;
         CALC:    if (calc_end) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         mplr_q <= '0;
         prod_q <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         wa3_q  <= '0;
         wd3_q  <= '0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               op_q   <= op;
               a_q    <= a;
               b_q    <= b;
               rd_q   <= rd;
               cnt_q  <= '0;
               mplr_q <= b;
               prod_q <= '0;
               rem_q  <= '0;
               quo_q  <= a;
            end
            CALC: if (!calc_end) begin
               prod_q <= prod_next;
               mplr_q <= mplr_q >> 1;
               rem_q  <= rem_next;
               quo_q  <= quo_next;
               cnt_q  <= cnt_q + CW'(1);
            end else begin
               wd3_q <= result;
               wa3_q <= rd_q;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   // Register 31 is the zero register: report completion but never write it.
   assign we3  = done && (wa3_q != 5'd31);
   assign wa3  = wa3_q;
   assign wd3  = wd3_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results per op, XZR, busy collision, abort.
module tb_muldiv_unit;

   localparam int N = 64;

   logic         clk, reset, start;
   logic [1:0]   op;
   logic [N-1:0] a, b;
   logic [4:0]   rd;
   logic         busy, done, we3;
   logic [4:0]   wa3;
   logic [N-1:0] wd3;

   int checks   = 0;
   int failures = 0;

   muldiv_unit #(.N(N)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .rd(rd),
      .busy(busy), .done(done), .we3(we3), .wa3(wa3), .wd3(wd3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required earlier", $time);
      $fatal(1, "watchdog");
   end

   // Issues one op, scrambles inputs after the accepting edge, and reports what was seen.
   task automatic run_op(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic [4:0] r, output int lat, output logic bz0,
                         output logic [N-1:0] wd, output logic we, output logic [4:0] wa,
                         output logic bzd, output logic dn_after, output logic bz_after);
      start = 1'b1; op = o; a = x; b = y; rd = r;
      @(posedge clk); #1;
      bz0 = busy;
      start = 1'b0; op = ~o; a = ~x ^ 64'h1234_5678_9ABC_DEF0; b = ~y; rd = ~r;
      lat = -1; wd = '0; we = 1'b0; wa = '0; bzd = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = k; wd = wd3; we = we3; wa = wa3; bzd = busy;
            break;
         end
      end
      @(posedge clk); #1;
      dn_after = done; bz_after = busy;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; rd = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, we3} !== 3'b000) begin
         failures++; $display("FAIL reset_flags: got %b required 000", {busy, done, we3});
      end
      checks++;
      if (wa3 !== 5'd0 || wd3 !== '0) begin
         failures++; $display("FAIL reset_regs: got wa3=%0d wd3=%h required 0", wa3, wd3);
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_mul();
      int lat; logic bz0, we, bzd, dna, bza; logic [N-1:0] wd; logic [4:0] wa;
      run_op(2'b00, 64'd7, 64'd6, 5'd3, lat, bz0, wd, we, wa, bzd, dna, bza);
      checks++;
      if (bz0 !== 1'b1) begin failures++; $display("FAIL mul_busy_accept: got %b required 1", bz0); end
      checks++;
      if (lat != N + 1) begin failures++; $display("FAIL mul_latency: got %0d required %0d", lat, N + 1); end
      checks++;
      if (wd !== 64'd42) begin failures++; $display("FAIL mul_wd3: got %0d required 42", wd); end
      checks++;
      if (we !== 1'b1 || wa !== 5'd3) begin
         failures++; $display("FAIL mul_we3_wa3: got we3=%b wa3=%0d required 1/3", we, wa);
      end
      checks++;
      if (bzd !== 1'b1) begin failures++; $display("FAIL mul_busy_done: got %b required 1", bzd); end
      checks++;
      if (dna !== 1'b0 || bza !== 1'b0) begin
         failures++; $display("FAIL mul_after_done: got done=%b busy=%b required 0/0", dna, bza);
      end
   endtask

   task automatic test_umulh();
      int lat; logic bz0, we, bzd, dna, bza; logic [N-1:0] wd; logic [4:0] wa;
      run_op(2'b01, '1, '1, 5'd5, lat, bz0, wd, we, wa, bzd, dna, bza);
      checks++;
      if (wd !== 64'hFFFF_FFFF_FFFF_FFFE || wa !== 5'd5) begin
         failures++; $display("FAIL umulh_max: got %h rd=%0d required fffffffffffffffe rd=5", wd, wa);
      end
      run_op(2'b00, '1, '1, 5'd5, lat, bz0, wd, we, wa, bzd, dna, bza);
      checks++;
      if (wd !== 64'd1) begin failures++; $display("FAIL mul_max_low: got %h required 1", wd); end
      run_op(2'b01, 64'h1_0000_0000, 64'h3_0000_0000, 5'd6, lat, bz0, wd, we, wa, bzd, dna, bza);
      checks++;
      if (wd !== 64'd3) begin failures++; $display("FAIL umulh_2pow64: got %h required 3", wd); end
   endtask

   task automatic test_div();
      int lat; logic bz0, we, bzd, dna, bza; logic [N-1:0] wd; logic [4:0] wa;
      run_op(2'b10, 64'd100, 64'd7, 5'd10, lat, bz0, wd, we, wa, bzd, dna, bza);
      checks++;
      if (wd !== 64'd14) begin failures++; $display("FAIL udiv_100_7: got %0d required 14", wd); end
      run_op(2'b11, 64'd100, 64'd7, 5'd11, lat, bz0, wd, we, wa, bzd, dna, bza);
      checks++;
      if (wd !== 64'd2) begin failures++; $display("FAIL urem_100_7: got %0d required 2", wd); end
      run_op(2'b10, 64'd100, 64'd0, 5'd12, lat, bz0, wd, we, wa, bzd, dna, bza);
      checks++;
      if (wd !== 64'd0 || lat != N + 1) begin
         failures++; $display("FAIL udiv_by0: got %0d lat=%0d required 0 lat=%0d", wd, lat, N + 1);
      end
      run_op(2'b11, 64'd100, 64'd0, 5'd13, lat, bz0, wd, we, wa, bzd, dna, bza);
      checks++;
      if (wd !== 64'd100 || lat != N + 1) begin
         failures++; $display("FAIL urem_by0: got %0d lat=%0d required 100 lat=%0d", wd, lat, N + 1);
      end
      run_op(2'b10, '1, 64'd10, 5'd14, lat, bz0, wd, we, wa, bzd, dna, bza);
      checks++;
      if (wd !== 64'h1999_9999_9999_9999) begin
         failures++; $display("FAIL udiv_max_10: got %h required 1999999999999999", wd);
      end
      run_op(2'b11, '1, 64'd10, 5'd15, lat, bz0, wd, we, wa, bzd, dna, bza);
      checks++;
      if (wd !== 64'd5) begin failures++; $display("FAIL urem_max_10: got %0d required 5", wd); end
   endtask

   task automatic test_xzr();
      int lat; logic bz0, we, bzd, dna, bza; logic [N-1:0] wd; logic [4:0] wa;
      run_op(2'b00, 64'd3, 64'd4, 5'd31, lat, bz0, wd, we, wa, bzd, dna, bza);
      checks++;
      if (lat != N + 1) begin failures++; $display("FAIL xzr_done: got lat=%0d required %0d", lat, N + 1); end
      checks++;
      if (we !== 1'b0 || wd !== 64'd12) begin
         failures++; $display("FAIL xzr_we3: got we3=%b wd3=%0d required 0/12", we, wd);
      end
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (wd3 !== 64'd12 || wa3 !== 5'd31 || done !== 1'b0 || we3 !== 1'b0) begin
         failures++;
         $display("FAIL idle_hold: got wd3=%0d wa3=%0d done=%b we3=%b required 12/31/0/0", wd3, wa3, done, we3);
      end
   endtask

   task automatic test_back_to_back();
      int ndone, nlow, low_t, late_busy;
      int dt[2]; logic [N-1:0] dv[2]; logic [4:0] dw[2];
      ndone = 0; nlow = 0; low_t = -1; late_busy = 0;
      dt[0] = -1; dt[1] = -1; dv[0] = '0; dv[1] = '0; dw[0] = '0; dw[1] = '0;
      start = 1'b1; op = 2'b00; a = 64'd5; b = 64'd9; rd = 5'd7;
      @(posedge clk); #1;
      op = 2'b10; a = 64'd1000; b = 64'd10; rd = 5'd8;
      for (int t = 1; t <= 140; t++) begin
         @(posedge clk); #1;
         if (done && ndone < 2) begin
            dt[ndone] = t; dv[ndone] = wd3; dw[ndone] = wa3; ndone++;
         end
         if (t <= 132 && !busy) begin nlow++; low_t = t; end
         if (t > 132 && busy) late_busy++;
         if (t == 67) begin op = 2'b11; a = 64'd1000; b = 64'd7; rd = 5'd9; end
         if (t == 120) start = 1'b0;
      end
      checks++;
      if (dt[0] != N + 1 || dv[0] !== 64'd45 || dw[0] !== 5'd7) begin
         failures++; $display("FAIL b2b_first: got t=%0d wd3=%0d wa3=%0d required t=%0d 45 7", dt[0], dv[0], dw[0], N + 1);
      end
      checks++;
      if (dt[1] != 2 * N + 4 || dv[1] !== 64'd100 || dw[1] !== 5'd8) begin
         failures++; $display("FAIL b2b_second: got t=%0d wd3=%0d wa3=%0d required t=%0d 100 8", dt[1], dv[1], dw[1], 2 * N + 4);
      end
      checks++;
      if (nlow != 1 || low_t != N + 2) begin
         failures++; $display("FAIL b2b_idle_gap: got lows=%0d at t=%0d required 1 at t=%0d", nlow, low_t, N + 2);
      end
      checks++;
      if (late_busy != 0) begin
         failures++; $display("FAIL b2b_no_extra_accept: got %0d busy cycles required 0", late_busy);
      end
   endtask

   task automatic test_abort();
      int bad, lat; logic bz0, we, bzd, dna, bza; logic [N-1:0] wd; logic [4:0] wa;
      bad = 0;
      start = 1'b1; op = 2'b10; a = 64'd1000; b = 64'd3; rd = 5'd20;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if ({busy, done, we3} !== 3'b000 || wa3 !== 5'd0 || wd3 !== '0) begin
         failures++;
         $display("FAIL abort_clear: got busy=%b done=%b we3=%b wa3=%0d wd3=%h required all 0", busy, done, we3, wa3, wd3);
      end
      for (int t = 0; t < 100; t++) begin
         @(posedge clk); #1;
         if (done || we3 || busy) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL abort_quiet: got %0d active cycles required 0", bad); end
      run_op(2'b00, 64'd2, 64'd3, 5'd1, lat, bz0, wd, we, wa, bzd, dna, bza);
      checks++;
      if (wd !== 64'd6 || we !== 1'b1 || lat != N + 1) begin
         failures++; $display("FAIL after_abort: got wd3=%0d we3=%b lat=%0d required 6/1/%0d", wd, we, lat, N + 1);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_umulh();
      test_div();
      test_xzr();
      test_back_to_back();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
